// File: rtl/vga_timing_gen.sv
// 640x480 @ 60 Hz VGA raster generator: pixel-rate divider, h/v counters and
// registered sync/bright/frame_start decode aligned with the counters.
module vga_timing_gen #(
    parameter int CLK_DIV        = 4,
    parameter int H_TOTAL        = 800,
    parameter int H_SYNC         = 96,
    parameter int H_BRIGHT_START = 144,
    parameter int H_BRIGHT_END   = 784,
    parameter int V_TOTAL        = 525,
    parameter int V_SYNC         = 2,
    parameter int V_BRIGHT_START = 35,
    parameter int V_BRIGHT_END   = 515
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       bright,
    output logic       hSync,
    output logic       vSync,
    output logic       pixel_en,
    output logic       frame_start
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYN   = 10'(H_SYNC);
    localparam logic [9:0] V_SYN   = 10'(V_SYNC);
    localparam logic [9:0] H_BR_LO = 10'(H_BRIGHT_START);
    localparam logic [9:0] H_BR_HI = 10'(H_BRIGHT_END);
    localparam logic [9:0] V_BR_LO = 10'(V_BRIGHT_START);
    localparam logic [9:0] V_BR_HI = 10'(V_BRIGHT_END);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;
    logic [9:0]       h_next;
    logic [9:0]       v_next;
    logic             h_wrap;
    logic             v_wrap;

    // With CLK_DIV = 1 div is stuck at 0 and this strobe is permanently high.
    assign pixel_en = (div == DIV_LAST);

    always_comb begin
        div_next = pixel_en ? '0 : div + DIV_W'(1);
        h_wrap   = (hCount == H_LAST);
        v_wrap   = (vCount == V_LAST);
        h_next   = hCount;
        v_next   = vCount;
        if (pixel_en) begin
            h_next = h_wrap ? 10'd0 : hCount + 10'd1;
            if (h_wrap) begin
                v_next = v_wrap ? 10'd0 : vCount + 10'd1;
            end
        end
    end

    // Decode from next-state counters so the registered flags line up with
    // the counter values they describe, with no skew for renderers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div         <= '0;
            hCount      <= 10'd0;
            vCount      <= 10'd0;
            hSync       <= 1'b0;
            vSync       <= 1'b0;
            bright      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= div_next;
            hCount      <= h_next;
            vCount      <= v_next;
            hSync       <= (h_next >= H_SYN);
            vSync       <= (v_next >= V_SYN);
            bright      <= (h_next >= H_BR_LO) && (h_next < H_BR_HI) &&
                           (v_next >= V_BR_LO) && (v_next < V_BR_HI);
            frame_start <= pixel_en && h_wrap && v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default, scaled-down frame, CLK_DIV=1)
// checked every cycle against an arithmetic model of elapsed time since reset.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       br;
    logic       hs;
    logic       vs;
    logic       pe;
    logic       fs;
  } obs_t;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;

  logic [9:0] h0, v0, h1, v1, h2, v2;
  logic br0, hs0, vs0, pe0, fs0;
  logic br1, hs1, vs1, pe1, fs1;
  logic br2, hs2, vs2, pe2, fs2;
  obs_t g0, g1, g2;

  int total = 0;
  int bad = 0;
  int t0 = 0;
  int t1 = 0;
  int t2 = 0;
  int cyc = 0;
  int last_fs = -1;
  int fs_count = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut0 (
    .clk(clk), .reset(rst0), .hCount(h0), .vCount(v0), .bright(br0),
    .hSync(hs0), .vSync(vs0), .pixel_en(pe0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_TOTAL(40), .H_SYNC(5), .H_BRIGHT_START(8), .H_BRIGHT_END(36),
    .V_TOTAL(20), .V_SYNC(2), .V_BRIGHT_START(3), .V_BRIGHT_END(18)
  ) dut1 (
    .clk(clk), .reset(rst1), .hCount(h1), .vCount(v1), .bright(br1),
    .hSync(hs1), .vSync(vs1), .pixel_en(pe1), .frame_start(fs1)
  );

  vga_timing_gen #(.CLK_DIV(1)) dut2 (
    .clk(clk), .reset(rst2), .hCount(h2), .vCount(v2), .bright(br2),
    .hSync(hs2), .vSync(vs2), .pixel_en(pe2), .frame_start(fs2)
  );

  assign g0 = {h0, v0, br0, hs0, vs0, pe0, fs0};
  assign g1 = {h1, v1, br1, hs1, vs1, pe1, fs1};
  assign g2 = {h2, v2, br2, hs2, vs2, pe2, fs2};

  // Expected outputs after t clock edges out of reset: pure time arithmetic.
  function automatic obs_t model(int t, int cd, int ht, int hsy, int hbs, int hbe,
                                 int vt, int vsy, int vbs, int vbe);
    obs_t m;
    int pix, h, v;
    pix  = t / cd;
    h    = pix % ht;
    v    = (pix / ht) % vt;
    m.h  = 10'(h);
    m.v  = 10'(v);
    m.hs = !(h < hsy);
    m.vs = !(v < vsy);
    m.br = (h >= hbs) && (h < hbe) && (v >= vbs) && (v < vbe);
    m.pe = ((t % cd) == cd - 1);
    m.fs = (t > 0) && ((t % cd) == 0) && ((pix % (ht * vt)) == 0);
    return m;
  endfunction

  task automatic expect_eq(string tag, int got, int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      if (bad <= 30) $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check(string tag, obs_t got, obs_t exp);
    expect_eq({tag, ".hCount"}, int'(got.h), int'(exp.h));
    expect_eq({tag, ".vCount"}, int'(got.v), int'(exp.v));
    expect_eq({tag, ".bright"}, int'(got.br), int'(exp.br));
    expect_eq({tag, ".hSync"}, int'(got.hs), int'(exp.hs));
    expect_eq({tag, ".vSync"}, int'(got.vs), int'(exp.vs));
    expect_eq({tag, ".pixel_en"}, int'(got.pe), int'(exp.pe));
    expect_eq({tag, ".frame_start"}, int'(got.fs), int'(exp.fs));
  endtask

  task automatic check_all();
    check("def", g0, model(t0, 4, 800, 96, 144, 784, 525, 2, 35, 515));
    check("small", g1, model(t1, 2, 40, 5, 8, 36, 20, 2, 3, 18));
    check("div1", g2, model(t2, 1, 800, 96, 144, 784, 525, 2, 35, 515));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!rst0) t0++;
    if (!rst1) t1++;
    if (!rst2) t2++;
    @(negedge clk);
    check_all();
    if (g1.fs === 1'b1) begin
      fs_count++;
      if (last_fs >= 0) expect_eq("small.frame_period", cyc - last_fs, 1600);
      last_fs = cyc;
    end
  endtask

  initial begin
    int target;
    int hold;
    int n;

    // Reset held across three edges, then released between edges.
    repeat (3) tick();
    rst0 = 1'b0;
    rst1 = 1'b0;
    rst2 = 1'b0;

    repeat (4) tick();
    expect_eq("def.h_after_4", int'(h0), 1);
    repeat (4) tick();
    expect_eq("def.h_after_8", int'(h0), 2);

    // Last clock of pixel (799,10), then the line wrap edge.
    while (t0 < 8799 * 4 + 3) tick();
    expect_eq("def.pre_wrap_h", int'(h0), 799);
    expect_eq("def.pre_wrap_v", int'(v0), 10);
    expect_eq("def.pre_wrap_pe", int'(pe0), 1);
    tick();
    expect_eq("def.wrap_h", int'(h0), 0);
    expect_eq("def.wrap_v", int'(v0), 11);

    // Asynchronous reset somewhere inside pixel (400,11).
    target = 9200 * 4 + int'($urandom_range(0, 3));
    while (t0 < target) tick();
    expect_eq("def.mid_h", int'(h0), 400);
    expect_eq("def.mid_v", int'(v0), 11);
    #2;
    rst0 = 1'b1;
    rst1 = 1'b1;
    rst2 = 1'b1;
    t0 = 0;
    t1 = 0;
    t2 = 0;
    last_fs = -1;
    fs_count = 0;
    #1;
    check_all();

    hold = int'($urandom_range(1, 4));
    repeat (hold) tick();
    rst0 = 1'b0;
    rst1 = 1'b0;
    rst2 = 1'b0;

    // Two full small-instance frames; reset itself must not produce a pulse.
    n = 3400 + int'($urandom_range(0, 200));
    repeat (n) tick();
    expect_eq("small.frame_pulses", fs_count, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
